// File: rtl/regfile_writeback_arbiter.sv
// regfile_writeback_arbiter
//
// Shares the single write port of registers_bank between two writeback
// requesters. Port A is the ALU result and port B is the load unit.
//
// Arbitration is round-robin with a 1-bit priority pointer. The winning
// write is registered onto we/sel_in/data_in, so the bank is written one
// edge after the transfer.
//
// A busy scoreboard holds one bit per register. Decode sets a register's
// bit when it reserves that register as a destination. The bit clears when
// a writeback to that register transfers. Upstream logic uses the bits to
// stall on hazards.
//
// Ports
//   clock, reset            rising-edge clock; async active-low reset
//   a_valid/a_ready/a_sel/a_data   port A writeback handshake + payload
//   b_valid/b_ready/b_sel/b_data   port B writeback handshake + payload
//   rsv_valid, rsv_sel      decode reserves destination rsv_sel
//   flush                   synchronous clear of every busy bit
//   we, sel_in, data_in     registered write to registers_bank
//   busy                    bit r = 1: register r has a writeback outstanding

// One scoreboard bit for a nonzero register.
// Priority: flush > reserve (set) > writeback (clr) > hold.
module regfile_busy_cell (
  input  logic clock,
  input  logic reset,
  input  logic flush,
  input  logic set,
  input  logic clr,
  output logic busy
);

  always_ff @(posedge clock or negedge reset) begin
    if (!reset)      busy <= 1'b0;
    else if (flush)  busy <= 1'b0;
    else if (set)    busy <= 1'b1;
    else if (clr)    busy <= 1'b0;
  end

endmodule

module regfile_writeback_arbiter #(
  parameter int DATA_WIDTH = 32,
  parameter int SEL_WIDTH  = 5
) (
  input  logic                      clock,
  input  logic                      reset,
  input  logic                      a_valid,
  output logic                      a_ready,
  input  logic [SEL_WIDTH-1:0]      a_sel,
  input  logic [DATA_WIDTH-1:0]     a_data,
  input  logic                      b_valid,
  output logic                      b_ready,
  input  logic [SEL_WIDTH-1:0]      b_sel,
  input  logic [DATA_WIDTH-1:0]     b_data,
  input  logic                      rsv_valid,
  input  logic [SEL_WIDTH-1:0]      rsv_sel,
  input  logic                      flush,
  output logic                      we,
  output logic [SEL_WIDTH-1:0]      sel_in,
  output logic [DATA_WIDTH-1:0]     data_in,
  output logic [(1<<SEL_WIDTH)-1:0] busy
);

  localparam int NUM_REGS = 1 << SEL_WIDTH;

  typedef struct packed {
    logic [SEL_WIDTH-1:0]  sel;
    logic [DATA_WIDTH-1:0] data;
  } wb_req_t;

  wb_req_t a_req, b_req, win_req;
  logic    ptr;        // 0: A has priority, 1: B has priority
  logic    grant_a, grant_b, xfer;
  logic    win_nz;     // winning write targets a real register (not x0)

  assign a_req = '{sel: a_sel, data: a_data};
  assign b_req = '{sel: b_sel, data: b_data};

  // Grant is purely a function of the valids and ptr. Reset gates it so
  // that no handshake completes while reset is held low.
  always_comb begin
    grant_a = 1'b0;
    grant_b = 1'b0;
    if (reset) begin
      if (a_valid && b_valid) begin
        grant_a = ~ptr;
        grant_b =  ptr;
      end else begin
        grant_a = a_valid;
        grant_b = b_valid;
      end
    end
  end

  assign a_ready = grant_a;
  assign b_ready = grant_b;
  assign xfer    = grant_a | grant_b;
  assign win_req = grant_b ? b_req : a_req;
  assign win_nz  = |win_req.sel;

  // Priority moves away from whichever port just transferred.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset)    ptr <= 1'b0;
    else if (xfer) ptr <= grant_a;
  end

  // Registered bank write. x0 writes are accepted, but they never raise we.
  // sel_in/data_in hold their value while the arbiter is idle.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      we      <= 1'b0;
      sel_in  <= '0;
      data_in <= '0;
    end else begin
      we <= xfer & win_nz;
      if (xfer) begin
        sel_in  <= win_req.sel;
        data_in <= win_req.data;
      end
    end
  end

  // Scoreboard. Register 0 is hardwired, so it has no cell.
  assign busy[0] = 1'b0;

  for (genvar r = 1; r < NUM_REGS; r++) begin : g_busy
    logic set, clr;
    assign set = rsv_valid && (rsv_sel == SEL_WIDTH'(r));
    assign clr = xfer && (win_req.sel == SEL_WIDTH'(r));

    regfile_busy_cell u_cell (
      .clock (clock),
      .reset (reset),
      .flush (flush),
      .set   (set),
      .clr   (clr),
      .busy  (busy[r])
    );
  end

endmodule

// File: tb/tb_regfile_writeback_arbiter.sv
module tb_regfile_writeback_arbiter;

  localparam int DW = 32;
  localparam int SW = 5;

  logic          clock = 1'b0;
  logic          reset;
  logic          a_valid, b_valid, a_ready, b_ready;
  logic [SW-1:0] a_sel, b_sel, rsv_sel, sel_in;
  logic [DW-1:0] a_data, b_data, data_in;
  logic          rsv_valid, flush, we;
  logic [31:0]   busy;

  int n_run  = 0;
  int n_fail = 0;

  logic [DW-1:0] bank [32];

  regfile_writeback_arbiter #(.DATA_WIDTH(DW), .SEL_WIDTH(SW)) dut (
    .clock(clock), .reset(reset),
    .a_valid(a_valid), .a_ready(a_ready), .a_sel(a_sel), .a_data(a_data),
    .b_valid(b_valid), .b_ready(b_ready), .b_sel(b_sel), .b_data(b_data),
    .rsv_valid(rsv_valid), .rsv_sel(rsv_sel), .flush(flush),
    .we(we), .sel_in(sel_in), .data_in(data_in), .busy(busy)
  );

  always #5 clock = ~clock;

  // Behavioural bank stand-in, used to confirm the end-to-end write.
  always @(posedge clock) if (we) bank[sel_in] <= data_in;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_run++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clock);
    #1;
  endtask

  initial begin
    for (int i = 0; i < 32; i++) bank[i] = '0;
    reset = 1'b0;
    a_valid = 1'b1; a_sel = 5'd7; a_data = 32'h77;
    b_valid = 1'b0; b_sel = '0;   b_data = '0;
    rsv_valid = 1'b0; rsv_sel = '0; flush = 1'b0;

    // Reset held low: no handshake, outputs cleared
    repeat (3) step();
    chk("rst_a_ready", a_ready, 0);
    chk("rst_we", we, 0);
    chk("rst_busy", busy, 0);
    chk("rst_sel_in", sel_in, 0);
    chk("rst_data_in", data_in, 0);

    // Release: the first edge grants A
    reset = 1'b1; #1;
    chk("rel_a_ready", a_ready, 1);
    step();
    a_valid = 1'b0;
    chk("rel_we", we, 1);
    chk("rel_sel_in", sel_in, 7);
    chk("rel_data_in", data_in, 32'h77);
    // ptr now points to B

    // Single port A while ptr favours B: A still wins because B is idle
    a_valid = 1'b1; a_sel = 5'd5; a_data = 32'hDEAD_BEEF; #1;
    chk("sp_a_ready", a_ready, 1);
    chk("sp_b_ready", b_ready, 0);
    step();
    a_valid = 1'b0;
    chk("sp_we", we, 1);
    chk("sp_sel_in", sel_in, 5);
    chk("sp_data_in", data_in, 32'hDEAD_BEEF);
    step();
    chk("sp_we_drop", we, 0);
    chk("sp_sel_hold", sel_in, 5);
    chk("sp_bank5", bank[5], 32'hDEAD_BEEF);

    // x0 write on B: accepted, no we, ptr flips back to A
    b_valid = 1'b1; b_sel = 5'd0; b_data = 32'd7; #1;
    chk("x0_b_ready", b_ready, 1);
    step();
    b_valid = 1'b0;
    chk("x0_we", we, 0);

    // Contention from ptr=0: A,B,A,B
    a_valid = 1'b1; a_sel = 5'd1; a_data = 32'h11;
    b_valid = 1'b1; b_sel = 5'd2; b_data = 32'h22;
    for (int i = 0; i < 4; i++) begin
      #1;
      chk($sformatf("ct_a_ready%0d", i), a_ready, (i % 2 == 0));
      chk($sformatf("ct_b_ready%0d", i), b_ready, (i % 2 == 1));
      step();
      chk($sformatf("ct_sel%0d", i), sel_in, (i % 2 == 0) ? 1 : 2);
      chk($sformatf("ct_data%0d", i), data_in, (i % 2 == 0) ? 32'h11 : 32'h22);
    end
    a_valid = 1'b0; b_valid = 1'b0;
    // the last grant was B, so ptr = 0

    // Scoreboard: a reserve becomes visible after the edge
    rsv_valid = 1'b1; rsv_sel = 5'd9; #1;
    chk("sb_no_comb", busy, 0);
    step();
    rsv_valid = 1'b0;
    chk("sb_rsv9", busy, 32'h0000_0200);

    // A writeback to 9 clears the bit at the transfer edge
    a_valid = 1'b1; a_sel = 5'd9; a_data = 32'h99;
    step();
    chk("sb_clr9", busy, 0);
    chk("sb_clr9_we", we, 1);

    // Same-cycle reserve and writeback to 9: the set wins
    rsv_valid = 1'b1; rsv_sel = 5'd9;
    step();
    rsv_valid = 1'b0;
    chk("sb_set_wins", busy, 32'h0000_0200);
    step();           // A still valid to 9: clears it
    a_valid = 1'b0;
    chk("sb_clr9b", busy, 0);

    // Reserving x0 does nothing; reg 31 is the top index
    rsv_valid = 1'b1; rsv_sel = 5'd0;
    step();
    chk("sb_rsv0", busy, 0);
    rsv_sel = 5'd31;
    step();
    chk("sb_rsv31", busy, 32'h8000_0000);
    rsv_sel = 5'd3; step();
    rsv_sel = 5'd4; step();
    rsv_valid = 1'b0;
    chk("fl_pre", busy, 32'h8000_0018);

    // Flush beats the reserve of 6 and does not cancel the A write to 3
    flush = 1'b1; rsv_valid = 1'b1; rsv_sel = 5'd6;
    a_valid = 1'b1; a_sel = 5'd3; a_data = 32'h33;
    step();
    flush = 1'b0; rsv_valid = 1'b0; a_valid = 1'b0;
    chk("fl_busy", busy, 0);
    chk("fl_we", we, 1);
    chk("fl_sel_in", sel_in, 3);
    chk("fl_data_in", data_in, 32'h33);

    // Reset during a pending write: we drops at once
    rsv_valid = 1'b1; rsv_sel = 5'd12;
    a_valid = 1'b1; a_sel = 5'd12; a_data = 32'hCC;
    step();
    rsv_valid = 1'b0;
    chk("mr_we_pre", we, 1);
    chk("mr_busy_pre", busy, 32'h0000_1000);
    reset = 1'b0; #1;
    chk("mr_we", we, 0);
    chk("mr_sel_in", sel_in, 0);
    chk("mr_data_in", data_in, 0);
    chk("mr_busy", busy, 0);
    chk("mr_a_ready", a_ready, 0);

    $display("[TB] %0d tests run, %0d failed", n_run, n_fail);
    $finish;
  end

endmodule

// File: doc/regfile_writeback_arbiter.md
# regfile_writeback_arbiter

Shares the single write port of `registers_bank` between two writeback requesters: port A (ALU result) and port B (load unit). Fair round-robin arbitration with valid/ready handshakes; the winning write is registered onto the bank's `we`/`sel_in`/`data_in`. A 32-entry busy scoreboard tracks destination registers reserved at decode and not yet written back, for hazard stalling upstream.

## Interface

- `DATA_WIDTH`, 32, width of register data
- `SEL_WIDTH`, 5, register index width (2**SEL_WIDTH registers)
- `clock`  in  1  single clock, rising edge
- `reset`  in  1  asynchronous, active-low (0 = reset)
- `a_valid`  in  1  port A has a write pending
- `a_ready`  out  1  port A write accepted this cycle
- `a_sel`  in  SEL_WIDTH  port A destination register
- `a_data`  in  DATA_WIDTH  port A write data
- `b_valid`, `b_ready`, `b_sel`, `b_data`: same as port A, for port B
- `rsv_valid`  in  1  decode reserves a destination register this cycle
- `rsv_sel`  in  SEL_WIDTH  register being reserved
- `flush`  in  1  synchronous clear of all busy bits
- `we`  out  1  to `registers_bank.we`
- `sel_in`  out  SEL_WIDTH  to `registers_bank.sel_in`
- `data_in`  out  DATA_WIDTH  to `registers_bank.data_in`
- `busy`  out  2**SEL_WIDTH  bit r = 1: register r reserved, writeback outstanding

## Operation

- Transfer on port X: `X_valid & X_ready` at a rising edge. At most one transfer per cycle; arbiter always accepts one write per cycle.
- Requester holds valid/sel/data stable until its ready; valid never withdrawn before transfer.
- Grant (combinational): only A valid -> A; only B valid -> B; both -> owner of priority pointer `ptr`; neither -> no grant. `X_ready` = grant to X.
- `ptr` (1 bit, internal): 0 = A priority. After any transfer on X, `ptr` points to the other port. Unchanged when idle.
- Write register: on transfer edge `we` <= 1 if granted sel != 0, else 0; `sel_in`/`data_in` <= granted sel/data. No transfer: `we` <= 0, `sel_in`/`data_in` hold last value.
- x0 writes: accepted (ready asserted, pointer advances), never drive `we`=1, never touch busy.
- Scoreboard, per register r != 0, at each edge in this priority:
  - `flush` -> 0 (overrides everything, including same-cycle reserve)
  - `rsv_valid & rsv_sel == r` -> 1 (set beats a same-cycle clear of r)
  - transfer with granted sel == r -> 0
  - else hold
- `busy[0]` constant 0. Reserving an already-busy register keeps it busy (single outstanding producer per register is decode's responsibility).
- `flush` does not cancel a transfer in the same cycle nor the registered write it produces.

## Timing

- Reset (`reset`=0, async): `we`=0, `sel_in`=0, `data_in`=0, `busy`=0, `ptr`=0; `a_ready`=`b_ready`=0 while reset low. Reset mid-transfer discards the pending registered write (`we` drops immediately).
- First edge after `reset` rises: normal operation.
- Latency: transfer at edge N -> `we`/`sel_in`/`data_in` valid during cycle N..N+1 -> bank written at edge N+1.
- Busy clear takes effect at the transfer edge N (same cycle `we` rises); reserve visible on `busy` the cycle after `rsv_valid` sampled.
- Ready is combinational from valid and `ptr`; no combinational path from `rsv_*`/`flush` to any output.
- Sustained both-valid: grants alternate A, B, A, B… starting from `ptr`.

## Test plan

- Reset: hold `reset`=0 with `a_valid`=1 -> `a_ready`=0, `we`=0, `busy`=0; release -> first edge grants A, next cycle `we`=1, `sel_in`=a_sel.
- Single port: `a_valid`=1, `a_sel`=5, `a_data`=0xDEAD_BEEF, one cycle -> `a_ready`=1, next cycle `we`=1, `sel_in`=5, `data_in`=0xDEADBEEF; following cycle `we`=0; bank reads 0xDEADBEEF on reg 5.
- Contention: both valid 4 cycles, A sel 1/data 0x11, B sel 2/data 0x22, `ptr`=0 -> grants A,B,A,B; `sel_in` sequence 1,2,1,2 one cycle later.
- x0: `b_valid`=1, `b_sel`=0, `b_data`=7 -> `b_ready`=1, `we` stays 0, `ptr` flips to A.
- Scoreboard: reserve 9 -> `busy[9]`=1; A writes 9 -> `busy[9]`=0 at transfer edge; same-cycle reserve 9 + write 9 -> `busy[9]`=1; reserve 0 -> `busy[0]`=0.
- Flush: busy bits 3 and 4 set, `flush`=1 with `rsv_valid`, `rsv_sel`=6 and A transfer to 3 -> `busy`=0 next cycle, `we`=1 `sel_in`=3 still issued.
